keypad_scanner: RTL and testbench

//  - Upstream stage of the keypad path. Drives the 4x4 keypad columns, reads the rows, debounces them,
//    and emits a 4-bit key code with a one-cycle valid pulse per press.
//  - Output feeds the digit-store / button-pulse logic in KeyPadController, in place of the mock decoder.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_row_sync.sv | 21 ++
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } scan_state_t;

  // Bit 4 set means "no key"; bits 3:0 carry the key code otherwise.
  typedef logic [4:0] key_t;
  localparam key_t NO_KEY = 5'b1_0000;

  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  localparam logic [3:0] COL_ONECOLD [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Exactly one low row yields a key; none or several (ghosting) yield NO_KEY.
  function automatic key_t decode_key(input logic [3:0] rows, input logic [1:0] col);
    key_t k;
    k = NO_KEY;
    case (rows)
      4'b1110: k = {1'b0, KEYMAP[0][col]};
      4'b1101: k = {1'b0, KEYMAP[1][col]};
      4'b1011: k = {1'b0, KEYMAP[2][col]};
      4'b0111: k = {1'b0, KEYMAP[3][col]};
      default: k = NO_KEY;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 2-flop synchronizer for the asynchronous active-low keypad rows.
module keypad_row_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_row,
  output logic [3:0] o_row
);

  logic [3:0] r_meta;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      o_row  <= '1;
    end else begin
      r_meta <= i_row;
      o_row  <= r_meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives keypad columns, debounces rows, emits key code plus one-cycle valid.
// Defining KEYPAD_REPEAT_EN adds auto-repeat valid pulses while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = 64,
  parameter int unsigned REPEAT_RATE  = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyPad_row,
  output logic [3:0] keyPad_column,
  output logic [3:0] digit,
  output logic       valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]       w_rows;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  scan_state_t      r_state;
  logic [1:0]       r_col_idx;
  logic [1:0]       w_col_nxt;
  key_t             r_cand;
  key_t             w_key;
  logic [CNT_W-1:0] r_stab_cnt;
  logic [CNT_W-1:0] r_rel_cnt;
  logic [CNT_W-1:0] w_stab_nxt;
  logic [CNT_W-1:0] w_rel_nxt;

  keypad_row_sync u_row_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_row   (keyPad_row),
    .o_row   (w_rows)
  );

  always_ff @(posedge clk) begin
    if (!reset)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  always_comb begin
    w_tick     = (r_div == DIV_W'(SCAN_DIV - 1));
    w_key      = decode_key(w_rows, r_col_idx);
    w_col_nxt  = r_col_idx + 2'd1;
    w_stab_nxt = r_stab_cnt + 1'b1;
    w_rel_nxt  = r_rel_cnt + 1'b1;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] w_rep_nxt;
  logic [REP_W-1:0] w_rep_limit;
  logic             r_rep_armed;
  logic             w_rep_fire;

  // The counter restarts at every pulse; the first interval is the delay, later ones the rate.
  always_comb begin
    w_rep_nxt   = r_rep_cnt + 1'b1;
    w_rep_limit = r_rep_armed ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
    w_rep_fire  = (w_rep_nxt == w_rep_limit);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= SCAN;
      r_col_idx     <= '0;
      keyPad_column <= COL_ONECOLD[0];
      r_cand        <= '0;
      r_stab_cnt    <= '0;
      r_rel_cnt     <= '0;
      digit         <= '0;
      valid         <= 1'b0;
      key_held      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt     <= '0;
      r_rep_armed   <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          SCAN: begin
            if (w_key[4]) begin
              r_col_idx     <= w_col_nxt;
              keyPad_column <= COL_ONECOLD[w_col_nxt];
            end else begin
              r_cand     <= w_key;
              r_stab_cnt <= CNT_W'(1);
              if (DEBOUNCE_CNT == 1) begin
                digit    <= w_key[3:0];
                valid    <= 1'b1;
                key_held <= 1'b1;
                r_state  <= PRESSED;
              end else begin
                r_state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            // A mismatch returns to SCAN without stepping; rotation resumes on the following tick.
            if (w_key == r_cand) begin
              r_stab_cnt <= w_stab_nxt;
              if (w_stab_nxt == CNT_W'(DEBOUNCE_CNT)) begin
                digit    <= w_key[3:0];
                valid    <= 1'b1;
                key_held <= 1'b1;
                r_state  <= PRESSED;
              end
            end else begin
              r_state <= SCAN;
            end
          end
          PRESSED: begin
            if (w_key != r_cand) begin
              r_rel_cnt <= CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
              r_rep_cnt   <= '0;
              r_rep_armed <= 1'b0;
`endif
              if (DEBOUNCE_CNT == 1) begin
                key_held <= 1'b0;
                r_state  <= SCAN;
              end else begin
                r_state <= RELEASE;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (w_rep_fire) begin
              valid       <= 1'b1;
              r_rep_cnt   <= '0;
              r_rep_armed <= 1'b1;
            end else begin
              r_rep_cnt <= w_rep_nxt;
            end
`endif
          end
          RELEASE: begin
            // Any sample other than the held key, including a different key, counts toward release.
            if (w_key == r_cand) begin
              r_state <= PRESSED;
            end else begin
              r_rel_cnt <= w_rel_nxt;
              if (w_rel_nxt == CNT_W'(DEBOUNCE_CNT)) begin
                key_held <= 1'b0;
                r_state  <= SCAN;
              end
            end
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad stimulus checked every cycle against a tick-level behavioural model.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RDELAY   = 8;
  localparam int unsigned RRATE    = 2;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row   = 4'b1111;
  logic [3:0] col;
  logic [3:0] digit;
  logic       valid;
  logic       held;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY (RDELAY),
    .REPEAT_RATE  (RRATE)
`endif
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .keyPad_row    (row),
    .keyPad_column (col),
    .digit         (digit),
    .valid         (valid),
    .key_held      (held)
  );

  always #5 clk = ~clk;

  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  function automatic int decode(input logic [3:0] r, input int c);
    int low = 0;
    int which = -1;
    for (int i = 0; i < 4; i++) begin
      if (r[i] == 1'b0) begin
        low++;
        which = i;
      end
    end
    return (low == 1) ? keymap[which][c] : -1;
  endfunction

  // Model state: accepted key (-1 none), candidate streak, release streak, ticks held.
  int         m_cyc, m_col, m_accepted, m_cand, m_streak, m_rel, m_rep, m_key;
  logic [3:0] m_s1, m_s2, m_seen, m_digit;
  bit         m_valid, m_held;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cyc = 0; m_col = 0; m_accepted = -1; m_cand = 0; m_streak = 0; m_rel = 0; m_rep = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_digit = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_live = 1'b1;
    end else begin
      m_seen  = m_s2;
      m_s2    = m_s1;
      m_s1    = row;
      m_valid = 1'b0;
      if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
        m_key = decode(m_seen, m_col);
        if (m_accepted < 0) begin
          if (m_streak == 0) begin
            if (m_key < 0) m_col = (m_col + 1) % 4;
            else begin m_cand = m_key; m_streak = 1; end
          end else if (m_key == m_cand) m_streak++;
          else m_streak = 0;
          if (m_streak == DEB) begin
            m_accepted = m_cand; m_streak = 0; m_rel = 0; m_rep = 0;
            m_digit = 4'(m_cand); m_valid = 1'b1; m_held = 1'b1;
          end
        end else if (m_key == m_accepted) begin
          if (m_rel > 0) begin m_rel = 0; m_rep = 0; end
          else begin
            m_rep++;
`ifdef KEYPAD_REPEAT_EN
            if (m_rep >= RDELAY && (m_rep - RDELAY) % RRATE == 0) m_valid = 1'b1;
`endif
          end
        end else begin
          m_rel++; m_rep = 0;
          if (m_rel == DEB) begin m_accepted = -1; m_rel = 0; m_held = 1'b0; end
        end
      end
      m_cyc++;
    end
  end

  int checks = 0;
  int errors = 0;
  int nvalid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (m_live) begin
      chk("cyc_column", col, 4'hF ^ (4'h1 << m_col));
      chk("cyc_digit", digit, m_digit);
      chk("cyc_valid", valid, m_valid);
      chk("cyc_key_held", held, m_held);
    end
    if (valid === 1'b1) nvalid++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Waits for a fresh arrival at the target column, i.e. just after a tick edge.
  task automatic wait_col(input logic [3:0] target, input string name);
    int n = 0;
    while (col === target && n < 100) begin step(); n++; end
    while (col !== target && n < 200) begin step(); n++; end
    chk(name, col, target);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin step(); n++; end while (valid !== 1'b1 && n < 200);
    chk(name, valid, 1'b1);
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    while (held !== 1'b0 && n < 200) begin step(); n++; end
    chk(name, held, 1'b0);
  endtask

  logic [3:0] seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  bit moved;

  initial begin
    // 1: reset values and free-running column rotation
    run(3);
    chk("rst_column", col, 4'b1110);
    chk("rst_digit", digit, 4'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_key_held", held, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      chk("rotate", col, seq[e / 4]);
    end

    // 2: press '5' and hold, then release
    wait_col(4'b1101, "t2_col");
    row = 4'b1101; nvalid = 0;
    wait_valid("t2_valid");
    chk("t2_digit", digit, 4'h5);
    chk("t2_key_held", held, 1'b1);
    chk("t2_frozen", col, 4'b1101);
    run(40);
    chk("t2_single", nvalid, 1);
    row = 4'b1111;
    wait_release("t2_release");
    chk("t2_col_at_release", col, 4'b1101);
    run(4);
    chk("t2_resume", col, 4'b1011);

    // 3: bouncing row1 (low, high, low, low, low across ticks)
    wait_col(4'b1101, "t3_col");
    nvalid = 0;
    row = 4'b1101; run(4);
    row = 4'b1111; run(4);
    row = 4'b1101; run(8);
    chk("t3_early", nvalid, 0);
    run(4);
    chk("t3_accept", nvalid, 1);
    chk("t3_digit", digit, 4'h5);
    run(20);
    chk("t3_single", nvalid, 1);
    row = 4'b1111;
    wait_release("t3_release");

    // 4: ghost press, rows 0 and 3 low together
    wait_col(4'b1110, "t4_col");
    nvalid = 0; moved = 1'b0;
    row = 4'b0110;
    for (int i = 0; i < 40; i++) begin
      step();
      if (col !== 4'b1110) moved = 1'b1;
    end
    chk("t4_no_valid", nvalid, 0);
    chk("t4_key_held", held, 1'b0);
    chk("t4_rotating", moved, 1'b1);
    row = 4'b1111;

    // 5: 'E' then '0'
    wait_col(4'b1011, "t5_col_e");
    row = 4'b0111;
    wait_valid("t5_valid_e");
    chk("t5_digit_e", digit, 4'hE);
    row = 4'b1111;
    wait_release("t5_release_e");
    wait_col(4'b1110, "t5_col_0");
    row = 4'b0111;
    wait_valid("t5_valid_0");
    chk("t5_digit_0", digit, 4'h0);
    row = 4'b1111;
    wait_release("t5_release_0");

    // 6: reset while pressed
    wait_col(4'b1101, "t6_col");
    row = 4'b1101;
    wait_valid("t6_valid");
    chk("t6_key_held", held, 1'b1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_column", col, 4'b1110);
    chk("t6_rst_digit", digit, 4'h0);
    chk("t6_rst_valid", valid, 1'b0);
    chk("t6_rst_key_held", held, 1'b0);
    row = 4'b1111;
    step();
    rst_n = 1'b1;
    nvalid = 0;
    run(40);
    chk("t6_no_valid", nvalid, 0);

    // 7: hold '7' for 14 ticks past the press
    wait_col(4'b1110, "t7_col");
    row = 4'b1011; nvalid = 0;
    wait_valid("t7_valid");
    chk("t7_digit", digit, 4'h7);
    run(58);
`ifdef KEYPAD_REPEAT_EN
    chk("t7_count", nvalid, 5);
`else
    chk("t7_count", nvalid, 1);
`endif
    chk("t7_digit_kept", digit, 4'h7);
    row = 4'b1111;
    wait_release("t7_release");
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
